// File: rtl/jk_seq_pkg.sv
// Shared types and the JK truth table for the JK command sequencer.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_code_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } seq_state_e;

  function automatic logic jk_next(input jk_code_e code, input logic q);
    case (code)
      JK_HOLD:  return q;
      JK_RESET: return 1'b0;
      JK_SET:   return 1'b1;
      default:  return ~q;
    endcase
  endfunction

endpackage

// File: rtl/jk_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module jk_rr_arbiter
  import jk_seq_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  int            best_dist;
  logic [IW-1:0] best_idx;

  // Rotated distance from ptr; the smallest distance among active requests wins.
  always_comb begin
    best_dist = NREQ;
    best_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && (((i + NREQ - int'(ptr)) % NREQ) < best_dist)) begin
        best_dist = (i + NREQ - int'(ptr)) % NREQ;
        best_idx  = IW'(i);
      end
    end
    gnt = '0;
    if (best_dist < NREQ) gnt[best_idx] = 1'b1;
    gnt_idx = best_idx;
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Shares one JK flop among NREQ requesters, serving (code, length) commands round-robin.
// Optional q scoreboard enabled by defining JK_SCOREBOARD_EN.
module jk_cmd_sequencer
  import jk_seq_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CNTW = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [2*NREQ-1:0]        req_jk,
  input  logic [CNTW*NREQ-1:0]     req_len,
  output logic [NREQ-1:0]          req_ready,
  output logic [1:0]               jk,
  input  logic                     q,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     done,
  output logic                     err
);

  localparam int IW = $clog2(NREQ);

  seq_state_e      state, state_n;
  jk_code_e        jk_r, jk_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic [IW-1:0]   owner_r, owner_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic            done_r, done_n;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  jk_code_e        sel_code;
  logic [CNTW-1:0] sel_len;

  jk_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    sel_code = JK_HOLD;
    sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_code = jk_code_e'(req_jk[2*i +: 2]);
        sel_len  = req_len[CNTW*i +: CNTW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    jk_n      = jk_r;
    cnt_n     = cnt;
    owner_n   = owner_r;
    ptr_n     = ptr;
    done_n    = 1'b0;
    req_ready = '0;
    case (state)
      S_IDLE: begin
        req_ready = gnt;
        if (|gnt) begin
          state_n = S_RUN;
          jk_n    = sel_code;
          cnt_n   = sel_len;
          owner_n = gnt_idx;
          ptr_n   = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
        end
      end
      S_RUN: begin
        // cnt==0 marks the last code cycle; the flop sees LEN+1 cycles of code.
        if (cnt == '0) begin
          jk_n    = JK_HOLD;
          done_n  = 1'b1;
          state_n = S_DONE;
        end else begin
          cnt_n = cnt - CNTW'(1);
        end
      end
      S_DONE: state_n = S_IDLE;
      default: begin
        state_n = S_IDLE;
        jk_n    = JK_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jk_r    <= JK_HOLD;
      cnt     <= '0;
      owner_r <= '0;
      ptr     <= '0;
      done_r  <= 1'b0;
    end else begin
      jk_r    <= jk_n;
      cnt     <= cnt_n;
      owner_r <= owner_n;
      ptr     <= ptr_n;
      done_r  <= done_n;
    end
  end

  assign jk    = jk_r;
  assign busy  = (state != S_IDLE);
  assign owner = owner_r;
  assign done  = done_r;

`ifdef JK_SCOREBOARD_EN
  logic exp_q;
  logic err_r;

  // exp_q shadows the external flop; any divergence latches err until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= 1'b0;
      err_r <= 1'b0;
    end else begin
      exp_q <= jk_next(jk_r, exp_q);
      err_r <= err_r | (q != exp_q);
    end
  end

  assign err = err_r;
`else
  logic unused_q;
  assign unused_q = q;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench for jk_cmd_sequencer with a JK flop model on jk/q.
module tb_jk_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [7:0]  req_jk = '0;
  logic [15:0] req_len = '0;
  logic [3:0]  req_ready;
  logic [1:0]  jk;
  logic        q;
  logic        busy;
  logic [1:0]  owner;
  logic        done;
  logic        err;

  logic q_ff;
  logic force_q0 = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0] jk;
    logic       done;
  } ent_t;

  function automatic logic jk_ref(input logic [1:0] c, input logic qv);
    case (c)
      2'b00:   return qv;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~qv;
    endcase
  endfunction

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_ff <= 1'b0;
    else     q_ff <= jk_ref(jk, q_ff);
  end

  assign q = force_q0 ? 1'b0 : q_ff;

  jk_cmd_sequencer #(.NREQ(4), .CNTW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_jk    (req_jk),
    .req_len   (req_len),
    .req_ready (req_ready),
    .jk        (jk),
    .q         (q),
    .busy      (busy),
    .owner     (owner),
    .done      (done),
    .err       (err)
  );

  task automatic reset_dut();
    rst       = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({jk, busy, req_ready, err, done, owner} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b exp %b", {jk, busy, req_ready, err, done, owner}, 11'b0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({jk, busy, req_ready, err, done, owner} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b exp %b", {jk, busy, req_ready, err, done, owner}, 11'b0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_set_cmd();
    logic [3:0] exp_o;
    reset_dut();
    req_jk[1:0]  = 2'b10;
    req_len[3:0] = 4'd2;
    req_valid    = 4'b0001;
    #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL set_ready: got %b exp %b", req_ready, 4'b0001);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = '0;
      exp_o = {(k <= 3) ? 2'b10 : 2'b00, (k == 4), (k <= 4)};
      n_tests++;
      if ({jk, done, busy} !== exp_o || q !== (k >= 2) || owner !== 2'd0) begin
        n_fail++;
        $display("FAIL set_cycle%0d: got jk/done/busy=%b q=%b owner=%0d exp %b q=%b owner=0",
                 k, {jk, done, busy}, q, owner, exp_o, (k >= 2));
      end
    end
  endtask

  task automatic test_round_robin();
    reset_dut();
    req_jk    = 8'hFF;
    req_len   = '0;
    req_valid = 4'hF;
    for (int g = 0; g < 4; g++) begin
      #1;
      n_tests++;
      if (req_ready !== 4'(1 << g)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %b exp %b", g, req_ready, 4'(1 << g));
      end
      @(negedge clk);
      req_valid[g] = 1'b0;
      n_tests++;
      if (owner !== 2'(g) || jk !== 2'b11 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_run%0d: got owner=%0d jk=%b busy=%b exp owner=%0d jk=11 busy=1",
                 g, owner, jk, busy, g);
      end
      @(negedge clk);
      n_tests++;
      if (done !== 1'b1 || jk !== 2'b00 || q !== 1'((g + 1) & 1)) begin
        n_fail++;
        $display("FAIL rr_done%0d: got done=%b jk=%b q=%b exp done=1 jk=00 q=%0d",
                 g, done, jk, q, (g + 1) & 1);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_long_len();
    int order[3] = '{2, 3, 1};
    req_jk[3:2]  = 2'b01;
    req_len[7:4] = 4'd15;
    req_valid    = 4'b0010;
    #1;
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL long_ready: got %b exp %b", req_ready, 4'b0010);
    end
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = '0;
      n_tests++;
      if ({jk, done, busy} !== ((k <= 16) ? 4'b0101 : 4'b0011)) begin
        n_fail++;
        $display("FAIL long_cycle%0d: got %b exp %b", k, {jk, done, busy},
                 (k <= 16) ? 4'b0101 : 4'b0011);
      end
    end
    req_jk    = 8'b11_00_10_00;
    req_len   = '0;
    req_valid = 4'b1110;
    #1;
    n_tests++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL long_done_ready: got %b exp %b", req_ready, 4'b0000);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if (req_ready !== 4'(1 << order[j])) begin
        n_fail++;
        $display("FAIL long_rr%0d: got %b exp %b", j, req_ready, 4'(1 << order[j]));
      end
      @(negedge clk);
      req_valid[order[j]] = 1'b0;
      n_tests++;
      if (owner !== 2'(order[j])) begin
        n_fail++;
        $display("FAIL long_owner%0d: got %0d exp %0d", j, owner, order[j]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rst_mid_run();
    @(negedge clk);
    req_jk[7:6]    = 2'b10;
    req_len[15:12] = 4'd10;
    req_valid      = 4'b1000;
    #1;
    n_tests++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL abort_ready: got %b exp %b", req_ready, 4'b1000);
    end
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({jk, busy, owner} !== 5'b10_1_11) begin
      n_fail++;
      $display("FAIL abort_running: got %b exp %b", {jk, busy, owner}, 5'b10_1_11);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({jk, busy, owner, done, req_ready} !== 10'b0) begin
      n_fail++;
      $display("FAIL abort_rst: got %b exp %b", {jk, busy, owner, done, req_ready}, 10'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_tests++;
      if ({jk, done, busy} !== 4'b0) begin
        n_fail++;
        $display("FAIL abort_after%0d: got %b exp %b", k, {jk, done, busy}, 4'b0);
      end
    end
  endtask

  task automatic test_scoreboard();
    logic exp_err;
`ifdef JK_SCOREBOARD_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset_dut();
    req_jk[1:0]  = 2'b10;
    req_len[3:0] = 4'd5;
    req_valid    = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    force_q0 = 1'b1;
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_before: got %b exp %b", err, 1'b0);
    end
    @(negedge clk);
    force_q0 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      n_tests++;
      if (err !== exp_err) begin
        n_fail++;
        $display("FAIL sb_sticky%0d: got %b exp %b", k, err, exp_err);
      end
      @(negedge clk);
    end
    reset_dut();
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_cleared: got %b exp %b", err, 1'b0);
    end
  endtask

  task automatic test_random();
    ent_t       sched[$];
    ent_t       e;
    logic       pv[4];
    logic [1:0] pc[4];
    logic [3:0] pl[4];
    logic [1:0] mo;
    logic       mq;
    logic       ebusy;
    logic [3:0] exp_ready;
    bit         idle;
    int         mptr;
    int         g;
    reset_dut();
    mo   = '0;
    mq   = 1'b0;
    mptr = 0;
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0;
      pc[i] = '0;
      pl[i] = '0;
    end
    for (int c = 0; c < 600; c++) begin
      if (sched.size() > 0) begin
        e     = sched.pop_front();
        ebusy = 1'b1;
        idle  = 1'b0;
      end else begin
        e     = '{jk: 2'b00, done: 1'b0};
        ebusy = 1'b0;
        idle  = 1'b1;
      end
      n_tests++;
      if ({jk, done, busy, owner, q, err} !== {e.jk, e.done, ebusy, mo, mq, 1'b0}) begin
        n_fail++;
        $display("FAIL rand_out c=%0d: got jk,done,busy,owner,q,err=%b exp %b",
                 c, {jk, done, busy, owner, q, err}, {e.jk, e.done, ebusy, mo, mq, 1'b0});
      end
      mq = jk_ref(e.jk, mq);
      for (int i = 0; i < 4; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1;
          pc[i] = 2'($urandom_range(0, 3));
          pl[i] = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
        end
        req_valid[i]       = pv[i];
        req_jk[2*i +: 2]   = pc[i];
        req_len[4*i +: 4]  = pl[i];
      end
      #1;
      g = -1;
      if (idle) begin
        for (int k = 0; k < 4; k++) begin
          if (g < 0 && pv[(mptr + k) % 4]) g = (mptr + k) % 4;
        end
      end
      exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
      n_tests++;
      if (req_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL rand_ready c=%0d: got %b exp %b", c, req_ready, exp_ready);
      end
      if (g >= 0) begin
        for (int k = 0; k <= int'(pl[g]); k++) sched.push_back('{jk: pc[g], done: 1'b0});
        sched.push_back('{jk: 2'b00, done: 1'b1});
        mo    = 2'(g);
        mptr  = (g + 1) % 4;
        pv[g] = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_set_cmd();
    test_round_robin();
    test_long_len();
    test_rst_mid_run();
    test_scoreboard();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
